// File: rtl/sha256_result_checker.sv
// Tags double-SHA256 digests with nonces, compares byte-reversed digest against target, buffers hits in a FIFO.
// Latency: digest_valid -> found_valid two cycles; found_valid/found_ready handshake, hits dropped (overflow) when full.
// Optional: CHECKER_STOP_ON_FIND_EN stops the sweep at the first hit written.

module sha256_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             wr_en, rd_en;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_en    = pop && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign wr_en    = push && (!full || rd_en);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)
                count <= count + 1'b1;
            else if (rd_en && !wr_en)
                count <= count - 1'b1;
        end
    end
endmodule

module sha256_result_checker #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      nonce_base,
    input  logic [31:0]      nonce_last,
    input  logic [255:0]     target,
    input  logic [255:0]     digest_in,
    input  logic             digest_valid,
    output logic             found_valid,
    input  logic             found_ready,
    output logic [31:0]      found_nonce,
    output logic [255:0]     found_hash,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] hash_count
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state, state_nxt;
    logic [31:0]    nonce_cnt;
    logic           stg_vld, stg_hit;
    logic [31:0]    stg_nonce;
    logic [255:0]   stg_dat;
    logic [255:0]   digest_num;
    logic           accept, load, done_set, done_clr;
    logic           hit_push, fifo_pop, fifo_empty, fifo_full;

`ifdef CHECKER_STOP_ON_FIND_EN
    // Once a hit sits in the stage the sweep is over; nothing behind it counts.
    assign accept = digest_valid && (state == S_RUN) && !(stg_vld && stg_hit);
`else
    assign accept = digest_valid && (state == S_RUN);
`endif

    always_comb begin
        digest_num = '0;
        for (int i = 0; i < 32; i++)
            digest_num[8*i +: 8] = digest_in[8*(31-i) +: 8];
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done_set  = 1'b0;
        done_clr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!stop && start) begin
                    state_nxt = S_RUN;
                    load      = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (accept && nonce_cnt == nonce_last) begin
                    state_nxt = S_DONE;
                    done_set  = 1'b1;
                end
`ifdef CHECKER_STOP_ON_FIND_EN
                else if (stg_vld && stg_hit) begin
                    state_nxt = S_DONE;
                    done_set  = 1'b1;
                end
`endif
            end
            S_DONE: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                    done_clr  = 1'b1;
                end else if (start) begin
                    state_nxt = S_RUN;
                    load      = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            nonce_cnt  <= '0;
            hash_count <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            stg_vld    <= 1'b0;
            stg_hit    <= 1'b0;
            stg_nonce  <= '0;
            stg_dat    <= '0;
        end else begin
            state   <= state_nxt;
            stg_vld <= accept;
            if (accept) begin
                stg_hit   <= (digest_num <= target);
                stg_nonce <= nonce_cnt;
                stg_dat   <= digest_in;
            end
            if (load) begin
                nonce_cnt  <= nonce_base;
                hash_count <= '0;
            end else if (accept) begin
                nonce_cnt <= nonce_cnt + 32'd1;
                if (hash_count != '1)
                    hash_count <= hash_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (load || done_clr)
                done <= 1'b0;
            else if (done_set)
                done <= 1'b1;
            if (load)
                overflow <= 1'b0;
            else if (hit_push && fifo_full && !fifo_pop)
                overflow <= 1'b1;
        end
    end

    assign hit_push    = stg_vld && stg_hit;
    assign fifo_pop    = found_valid && found_ready;
    assign found_valid = !fifo_empty;
    assign busy        = (state == S_RUN);

    sha256_result_fifo #(
        .WIDTH (288),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (hit_push),
        .push_dat ({stg_nonce, stg_dat}),
        .pop      (fifo_pop),
        .head_dat ({found_nonce, found_hash}),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );
endmodule

// File: tb/tb_sha256_result_checker.sv
// Directed-vector bench: stimulus pushes expected hits to a scoreboard, a negedge monitor pops and compares.
module tb_sha256_result_checker;
    logic         CLK = 1'b0;
    logic         RST, start, stop, digest_valid, found_ready;
    logic [31:0]  nonce_base, nonce_last;
    logic [255:0] target, digest_in;
    logic         found_valid, busy, done, overflow;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic [31:0]  hash_count;

    typedef struct {
        logic [31:0]  n;
        logic [255:0] h;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    localparam logic [255:0] ONES    = '1;
    localparam logic [255:0] TGT_LOW = {32'h0, {224{1'b1}}};
    localparam logic [255:0] HIT3    = 256'h01 << 248;

    sha256_result_checker #(.FIFO_DEPTH(4), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop),
        .nonce_base(nonce_base), .nonce_last(nonce_last), .target(target),
        .digest_in(digest_in), .digest_valid(digest_valid),
        .found_valid(found_valid), .found_ready(found_ready),
        .found_nonce(found_nonce), .found_hash(found_hash),
        .busy(busy), .done(done), .overflow(overflow), .hash_count(hash_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && found_valid && found_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_hit: got nonce %0h, expected none", found_nonce);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hit_nonce", found_nonce, e.n);
                chk("hit_hash", found_hash, e.h);
            end
        end
    end

    function automatic logic [255:0] dg(input logic [31:0] i);
        return {8{32'hC0DE0000 + i}};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic go(input logic [31:0] base, input logic [31:0] last);
        nonce_base = base;
        nonce_last = last;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [255:0] d);
        digest_in = d;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++)
            tick();
        chk("drain", sb.size(), 0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; start = 0; stop = 0; digest_valid = 0; found_ready = 1;
        nonce_base = 0; nonce_last = 0; target = ONES; digest_in = 0;
        #1;
        do_reset();
        chk("rst_found_valid", found_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_hash_count", hash_count, 0);

        // hit/miss boundary: byte-reversed value equal to target hits, +1 misses
        target = TGT_LOW;
        go(32'h100, 32'h1FF);
        sb.push_back('{32'h100, {{224{1'b1}}, 32'h0}});
        send({{224{1'b1}}, 32'h0});
        repeat (3) tick();
        send(256'h0100_0000);
        wait_drain();
        repeat (2) tick();
        chk("bnd_found_valid", found_valid, 0);
`ifdef CHECKER_STOP_ON_FIND_EN
        chk("bnd_hash_count", hash_count, 1);
`else
        chk("bnd_hash_count", hash_count, 2);
`endif

        // only the 3rd of 8 digests hits
        do_reset();
        target = TGT_LOW;
        go(32'h500, 32'h507);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) sb.push_back('{32'h502, HIT3});
            send(i == 2 ? HIT3 : ONES);
        end
        wait_drain();
        repeat (2) tick();
`ifdef CHECKER_STOP_ON_FIND_EN
        chk("sof_hash_count", hash_count, 3);
`else
        chk("sof_hash_count", hash_count, 8);
`endif
        chk("sof_done", done, 1);
        chk("sof_busy", busy, 0);

`ifndef CHECKER_STOP_ON_FIND_EN
        // every digest hits, back-to-back; latency t+2
        do_reset();
        target = ONES;
        go(32'h10, 32'h13);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) chk("lat_t1", found_valid, 0);
            if (i == 2) chk("lat_t2", found_valid, 1);
            sb.push_back('{32'h10 + i, dg(i)});
            digest_in = dg(i);
            digest_valid = 1'b1;
            tick();
        end
        digest_valid = 1'b0;
        wait_drain();
        chk("all_done", done, 1);
        chk("all_hash_count", hash_count, 4);
        chk("all_busy", busy, 0);

        // overflow: 6 hits into a depth-4 FIFO with consumer stalled
        do_reset();
        found_ready = 1'b0;
        go(32'h200, 32'h2FF);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) sb.push_back('{32'h200 + i, dg(i + 8)});
            send(dg(i + 8));
        end
        repeat (3) tick();
        chk("ovf_flag", overflow, 1);
        chk("ovf_found_valid", found_valid, 1);
        found_ready = 1'b1;
        wait_drain();
        chk("ovf_drained", found_valid, 0);

        // sweep wrapping through 0xFFFFFFFF
        do_reset();
        go(32'hFFFF_FFFE, 32'h1);
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{32'hFFFF_FFFE + i, dg(i + 16)});
            digest_in = dg(i + 16);
            digest_valid = 1'b1;
            if (i == 3) chk("wrap_done_pre", done, 0);
            tick();
        end
        digest_valid = 1'b0;
        chk("wrap_done", done, 1);
        wait_drain();

        // stop mid-sweep; in-flight compare still lands
        do_reset();
        go(32'h300, 32'h3FF);
        sb.push_back('{32'h300, dg(20)});
        send(dg(20));
        sb.push_back('{32'h301, dg(21)});
        send(dg(21));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        send(dg(22));
        send(dg(23));
        wait_drain();
        repeat (2) tick();
        chk("stop_hash_count", hash_count, 2);
        chk("stop_found_valid", found_valid, 0);

        // start and stop together in IDLE
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("ss_busy", busy, 0);
        send(dg(24));
        repeat (3) tick();
        chk("ss_found_valid", found_valid, 0);

        // reset with a pending FIFO entry
        found_ready = 1'b0;
        go(32'h400, 32'h4FF);
        send(dg(25));
        repeat (2) tick();
        chk("rstp_pending", found_valid, 1);
        RST = 1'b1;
        tick();
        chk("rstp_found_valid", found_valid, 0);
        chk("rstp_hash_count", hash_count, 0);
        RST = 1'b0;
        found_ready = 1'b1;
        repeat (2) tick();
`endif

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sha256_result_checker.md
Name: sha256_result_checker

Overview:
- Sits directly downstream of the double-SHA256 core and consumes its final digest stream (digest bus plus third-stage valid strobe).
- Tags each in-order digest with its nonce and compares it against the mining target.
- Buffers winning nonce/hash pairs in a small FIFO and hands them to the host/UART side over a valid/ready handshake.
- Also counts hashes and reports sweep completion.

Parameters:
- FIFO_DEPTH, 4, number of buffered hits; power of two, minimum 2.
- CNT_W, 32, width of hash_count.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a nonce sweep.
- stop  in  1  one-cycle pulse; aborts the sweep.
- nonce_base  in  32  nonce of the first digest of the sweep.
- nonce_last  in  32  nonce of the final digest of the sweep.
- target  in  256  difficulty target, big-endian numeric.
- digest_in  in  256  final digest from the core.
- digest_valid  in  1  digest_in is valid this cycle (core valid_3_out).
- found_valid  out  1  FIFO head holds a hit.
- found_ready  in  1  consumer accepts the head.
- found_nonce  out  32  nonce of the head hit.
- found_hash  out  256  digest of the head hit, as produced by the core.
- busy  out  1  state is RUN.
- done  out  1  sticky; sweep reached nonce_last.
- overflow  out  1  sticky; a hit was dropped because the FIFO was full.
- hash_count  out  CNT_W  digests checked in the current sweep.

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high, sampled only on the rising edge of CLK.
- Reset values: all outputs 0, FIFO empty, state IDLE, nonce counter 0, compare stage invalid.
- States:
  - IDLE: start -> RUN. On the start edge: nonce_cnt <= nonce_base, hash_count <= 0, done <= 0, overflow <= 0. FIFO contents are kept.
  - RUN: digest_valid accepted each cycle. stop -> IDLE. Accepted digest whose nonce_cnt == nonce_last -> DONE, done <= 1.
  - DONE: start -> RUN with the same load as from IDLE. stop -> IDLE and clears done.
  - start is ignored in RUN. If start and stop arrive together in IDLE/DONE, stop wins and the block goes to IDLE.
- Digest acceptance:
  - Only in RUN. digest_valid in IDLE/DONE is ignored: no count, no compare.
  - Each accepted digest is tagged with the current nonce_cnt; then nonce_cnt increments mod 2^32 and hash_count increments, saturating at all-ones.
  - If nonce_base > nonce_last, the sweep wraps through 0xFFFFFFFF to 0.
- Compare stage (one register stage):
  - The digest is byte-reversed (byte 0 <-> byte 31) and treated as an unsigned 256-bit number H.
  - Hit when H <= target.
  - The stage register holds {hit, nonce, digest} and flows to the FIFO write on the next edge.
  - The final-nonce digest is still compared and written even though the state moves to DONE on the same edge.
  - stop does not flush an in-flight compare stage; it still writes.
- Latency: digest_valid high in cycle t with an empty FIFO -> found_valid high in cycle t+2, with found_nonce/found_hash valid.
- FIFO behaviour:
  - Pop occurs when found_valid && found_ready. Outputs are driven directly from the FIFO head.
  - Write while full without a same-cycle pop: the hit is dropped and overflow <= 1.
  - Write while full with a same-cycle pop: accepted, no overflow.
  - Simultaneous push and pop on an empty FIFO: the push is stored and found_valid rises the next cycle. There is no bypass.
- Reset mid-operation discards the FIFO, the in-flight compare and all counters.

Optional Feature:
- Macro: CHECKER_STOP_ON_FIND_EN.
- Defined: the first hit written in RUN forces the state to DONE and sets done.
  - Further digest_valid is ignored; the hit in flight is still written.
  - hash_count freezes at the count including the winning digest.
- Undefined: the sweep continues to nonce_last regardless of hits.

Test Plan:
- Hit on every digest: target = all-ones, nonce_base = 0x10, nonce_last = 0x13, four back-to-back digest_valid, found_ready = 1 -> hits with nonces 0x10..0x13 in order; first found_valid at t+2; done = 1; hash_count = 4.
- Hit/miss boundary: target = 0x00000000FFFF...FF, one digest with byte-reversed value exactly equal to target, then one greater by 1 -> only the first is reported.
- Overflow: FIFO_DEPTH = 4, found_ready = 0, target = all-ones, 6 digests -> 4 entries held, overflow = 1. Then raise found_ready -> nonces base..base+3 drain, and found_valid falls after 4 pops.
- Wrap sweep: nonce_base = 0xFFFFFFFE, nonce_last = 0x00000001 -> tags FFFFFFFE, FFFFFFFF, 0, 1; done after the 4th digest.
- Control/reset: stop mid-sweep -> busy = 0 and later digests ignored; start and stop in the same cycle in IDLE -> remains IDLE; RST asserted with a FIFO entry pending -> found_valid = 0 on the next cycle.
- With CHECKER_STOP_ON_FIND_EN: target hits only the 3rd digest of 8 -> one hit, done = 1 after it, hash_count = 3.
